// File: rtl/l2_wb_buffer_if.sv
// Request/response channel shared by the bus-side (up) and L2-side ports of
// the write-back buffer. The two ports are protocol-identical, so one
// interface type serves both; the buffer is the slave on the bus side and
// the master on the L2 side.
interface l2_wb_buffer_if #(
  parameter int AW = 26,
  parameter int LW = 512
);
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_rw;
  logic [LW-1:0] req_data;
  logic          resp_valid;
  logic [LW-1:0] resp_data;

  modport master (
    output req_valid, req_addr, req_rw, req_data,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr, req_rw, req_data,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/l2_wb_buffer.sv
// Write-back buffer between the coherence-bus L2 channel and the L2 cache.
// Bus writes land in a DEPTH-entry circular FIFO (coalescing on address
// match), drain to L2 one at a time, and bus reads are answered from the
// buffer on a hit or forwarded to L2 ahead of queued drains on a miss.
module l2_wb_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 26,
  parameter int LW    = 512
) (
  input  logic             clk,
  input  logic             reset,
  l2_wb_buffer_if.slave    up,
  l2_wb_buffer_if.master   l2,
  output logic             wb_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    P_IDLE,
    P_DRAIN,
    P_RD_REQ,
    P_RD_WAIT,
    P_RD_RESP
  } pstate_t;

  // write-buffer storage
  logic [DEPTH-1:0] ent_vld;
  logic [AW-1:0]    ent_addr [DEPTH];
  logic [LW-1:0]    ent_data [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;

  // L2 port FSM and outstanding-read tracking
  pstate_t          pst;
  logic             rd_busy;
  logic             rd_pend;
  logic [AW-1:0]    rd_addr;
  logic             l2_vld_q;
  logic             l2_rw_q;
  logic [AW-1:0]    l2_addr_q;
  logic [LW-1:0]    l2_data_q;
  logic             resp_vld_q;
  logic [LW-1:0]    resp_data_q;

  // address-match results
  logic             wr_hit;
  logic [PW-1:0]    wr_idx;
  logic             rd_hit;
  logic [PW-1:0]    rd_idx;
  logic [PW-1:0]    scan;

  logic             draining;
  logic             full;
  logic             ready;
  logic             wr_acc;
  logic             rd_acc;
  logic             enq;
  logic             coal;
  logic             pop;
  logic [LW-1:0]    head_data;

  assign draining = (pst == P_DRAIN);
  assign full     = (count == CW'(DEPTH));

  // Scan oldest to youngest so the last match is the youngest. The head
  // entry under drain is visible to reads but closed to coalescing, since
  // its data is already on the L2 bus.
  always_comb begin
    wr_hit = 1'b0;
    wr_idx = '0;
    rd_hit = 1'b0;
    rd_idx = '0;
    scan   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan = head + PW'(k);
      if (ent_vld[scan] && (ent_addr[scan] == up.req_addr)) begin
        rd_hit = 1'b1;
        rd_idx = scan;
        if (!(draining && (scan == head))) begin
          wr_hit = 1'b1;
          wr_idx = scan;
        end
      end
    end
  end

  // A full buffer only takes writes that coalesce; no same-cycle bypass of
  // a draining head. Reads are single-outstanding.
  assign ready  = !reset && up.req_valid &&
                  (up.req_rw ? (!full || wr_hit) : !rd_busy);
  assign wr_acc = ready &&  up.req_rw;
  assign rd_acc = ready && !up.req_rw;
  assign enq    = wr_acc && !wr_hit;
  assign coal   = wr_acc &&  wr_hit;
  assign pop    = draining && l2.req_ready;

  // When a drain starts on the same edge a write coalesces into the head,
  // the drain must carry the new data, not the stale copy.
  assign head_data = (coal && (wr_idx == head)) ? up.req_data : ent_data[head];

  assign up.req_ready  = ready;
  assign up.resp_valid = resp_vld_q;
  assign up.resp_data  = resp_data_q;
  assign l2.req_valid  = l2_vld_q;
  assign l2.req_rw     = l2_rw_q;
  assign l2.req_addr   = l2_addr_q;
  assign l2.req_data   = l2_data_q;
  assign wb_empty      = (count == '0) && !draining;

  // FIFO: coalesce in place, enqueue at tail, pop head on drain handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      ent_vld <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else begin
      if (coal) ent_data[wr_idx] <= up.req_data;
      if (enq) begin
        ent_vld[tail]  <= 1'b1;
        ent_addr[tail] <= up.req_addr;
        ent_data[tail] <= up.req_data;
        tail           <= tail + PW'(1);
      end
      if (pop) begin
        ent_vld[head] <= 1'b0;
        head          <= head + PW'(1);
      end
      count <= count + CW'(enq) - CW'(pop);
    end
  end

  // L2 port FSM plus read bookkeeping; all bus-facing outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      pst         <= P_IDLE;
      rd_busy     <= 1'b0;
      rd_pend     <= 1'b0;
      rd_addr     <= '0;
      l2_vld_q    <= 1'b0;
      l2_rw_q     <= 1'b0;
      l2_addr_q   <= '0;
      l2_data_q   <= '0;
      resp_vld_q  <= 1'b0;
      resp_data_q <= '0;
    end else begin
      resp_vld_q  <= 1'b0;
      resp_data_q <= '0;

      // any response cycle (hit or L2 return) frees the read slot
      if (resp_vld_q) rd_busy <= 1'b0;

      if (rd_acc) begin
        rd_busy <= 1'b1;
        rd_addr <= up.req_addr;
        if (rd_hit) begin
          resp_vld_q  <= 1'b1;
          resp_data_q <= ent_data[rd_idx];
        end else begin
          rd_pend <= 1'b1;
        end
      end

      case (pst)
        P_IDLE: begin
          if (rd_pend) begin
            pst       <= P_RD_REQ;
            l2_vld_q  <= 1'b1;
            l2_rw_q   <= 1'b0;
            l2_addr_q <= rd_addr;
            l2_data_q <= '0;
          end else if (count != '0) begin
            pst       <= P_DRAIN;
            l2_vld_q  <= 1'b1;
            l2_rw_q   <= 1'b1;
            l2_addr_q <= ent_addr[head];
            l2_data_q <= head_data;
          end
        end
        P_DRAIN: begin
          if (l2.req_ready) begin
            pst       <= P_IDLE;
            l2_vld_q  <= 1'b0;
            l2_rw_q   <= 1'b0;
            l2_addr_q <= '0;
            l2_data_q <= '0;
          end
        end
        P_RD_REQ: begin
          if (l2.req_ready) begin
            pst       <= P_RD_WAIT;
            rd_pend   <= 1'b0;
            l2_vld_q  <= 1'b0;
            l2_addr_q <= '0;
          end
        end
        P_RD_WAIT: begin
          if (l2.resp_valid) begin
            pst         <= P_RD_RESP;
            resp_vld_q  <= 1'b1;
            resp_data_q <= l2.resp_data;
          end
        end
        P_RD_RESP: pst <= P_IDLE;
        default:   pst <= P_IDLE;
      endcase
    end
  end
endmodule
